// File: rtl/mem_stage.sv
// MEM pipeline stage: data RAM, memory-mapped timer/LED/seven-segment peripherals,
// store-data forwarding from MEM/WB, and the MEM/WB pipeline register.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  MEMWBop,
    input  logic [31:0] EXMEM_ALUout,
    input  logic        EXMEM_RegWrite,
    input  logic        EXMEM_MemtoReg,
    input  logic        EXMEM_MemWrite,
    input  logic        EXMEM_MemRead,
    input  logic [4:0]  EXMEM_WriteRegAddr,
    input  logic [31:0] EXMEM_MemWriteData,
    input  logic [4:0]  EXMEM_rt,
    output logic        MEMWB_RegWrite,
    output logic [4:0]  MEMWB_WriteRegAddr,
    output logic [31:0] MEMWB_RegWriteData,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);

    typedef enum logic [1:0] {
        OP_ADVANCE = 2'd0,
        OP_FLUSH   = 2'd1,
        OP_STALL   = 2'd2,
        OP_HOLD    = 2'd3
    } memwb_op_t;

    logic [31:0] r_ram [0:255];
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [7:0]  r_leds;
    logic [11:0] r_digits;
    logic [31:0] r_systick;
    logic        r_regWrite;
    logic [4:0]  r_writeRegAddr;
    logic [31:0] r_regWriteData;

    logic        w_isRam;
    logic        w_isPeriph;
    logic [7:0]  w_ramIdx;
    logic [2:0]  w_periphSel;
    logic        w_forward;
    logic [31:0] w_storeData;
    logic        w_doWrite;
    logic [31:0] w_readData;
    logic        w_unused;
    memwb_op_t   w_op;

    assign w_op        = memwb_op_t'(MEMWBop);
    assign w_isRam     = (EXMEM_ALUout[31:10] == 22'd0);
    assign w_isPeriph  = (EXMEM_ALUout[31:5] == 27'h200_0000);
    assign w_ramIdx    = EXMEM_ALUout[9:2];
    assign w_periphSel = EXMEM_ALUout[4:2];

    // Bypass a value the instruction just ahead is about to write back; $zero never forwards.
    assign w_forward   = r_regWrite && (r_writeRegAddr == EXMEM_rt) && (EXMEM_rt != 5'd0);
    assign w_storeData = w_forward ? r_regWriteData : EXMEM_MemWriteData;
    assign w_doWrite   = EXMEM_MemWrite && (w_op == OP_ADVANCE) && !reset;

    // Loads read unconditionally; MemtoReg decides whether the value is used.
    assign w_unused    = ^{EXMEM_MemRead, EXMEM_ALUout[1:0]};

    always_comb begin
        w_readData = 32'd0;
        if (w_isRam) begin
            w_readData = r_ram[w_ramIdx];
        end else if (w_isPeriph) begin
            case (w_periphSel)
                3'd0:    w_readData = r_th;
                3'd1:    w_readData = r_tl;
                3'd2:    w_readData = {29'd0, r_tcon};
                3'd3:    w_readData = {24'd0, r_leds};
                3'd4:    w_readData = {20'd0, r_digits};
                3'd5:    w_readData = r_systick;
                default: w_readData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doWrite && w_isRam) begin
            r_ram[w_ramIdx] <= w_storeData;
        end
    end

    // Software writes come after the timer update so they override it in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th      <= 32'd0;
            r_tl      <= 32'd0;
            r_tcon    <= 3'd0;
            r_leds    <= 8'd0;
            r_digits  <= 12'd0;
            r_systick <= 32'd0;
        end else begin
            r_systick <= r_systick + 32'd1;
            if (r_tcon[0]) begin
                if (r_tl == 32'hFFFF_FFFF) begin
                    r_tl <= r_th;
                    if (r_tcon[1]) begin
                        r_tcon[2] <= 1'b1;
                    end
                end else begin
                    r_tl <= r_tl + 32'd1;
                end
            end
            if (w_doWrite && w_isPeriph) begin
                case (w_periphSel)
                    3'd0:    r_th     <= w_storeData;
                    3'd1:    r_tl     <= w_storeData;
                    3'd2:    r_tcon   <= w_storeData[2:0];
                    3'd3:    r_leds   <= w_storeData[7:0];
                    3'd4:    r_digits <= w_storeData[11:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regWrite     <= 1'b0;
            r_writeRegAddr <= 5'd0;
            r_regWriteData <= 32'd0;
        end else begin
            case (w_op)
                OP_ADVANCE: begin
                    r_regWrite     <= EXMEM_RegWrite;
                    r_writeRegAddr <= EXMEM_WriteRegAddr;
                    r_regWriteData <= EXMEM_MemtoReg ? w_readData : EXMEM_ALUout;
                end
                OP_FLUSH: begin
                    r_regWrite     <= 1'b0;
                    r_writeRegAddr <= 5'd0;
                    r_regWriteData <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign MEMWB_RegWrite     = r_regWrite;
    assign MEMWB_WriteRegAddr = r_writeRegAddr;
    assign MEMWB_RegWriteData = r_regWriteData;
    assign leds               = r_leds;
    assign digits             = r_digits;
    assign irq                = r_tcon[2];

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 MEMWBop  in  2  0 = advance, 1 = flush (load bubble), 2 = stall (hold); 3 behaves as 2.
REQ-004 EXMEM_ALUout  in  32  ALU result / byte address for loads and stores.
REQ-005 EXMEM_RegWrite, EXMEM_MemtoReg, EXMEM_MemWrite, EXMEM_MemRead  in  1 each  control bits from the EX/MEM register.
REQ-006 EXMEM_WriteRegAddr  in  5  destination register.
REQ-007 EXMEM_MemWriteData  in  32  store data before forwarding.
REQ-008 EXMEM_rt  in  5  register ID that sourced EXMEM_MemWriteData.
REQ-009 MEMWB_RegWrite  out  1  registered write enable to the register file.
REQ-010 MEMWB_WriteRegAddr  out  5  registered destination register.
REQ-011 MEMWB_RegWriteData  out  32  registered write-back data; this is also the WB forwarding source for EX.
REQ-012 leds  out  8  LED register.
REQ-013 digits  out  12  seven-segment register.
REQ-014 irq  out  1  timer interrupt, equal to TCON[2].

Function
REQ-015 Store data SHALL be forwarded from the MEM/WB register when MEMWB_RegWrite=1, MEMWB_WriteRegAddr=EXMEM_rt and EXMEM_rt≠0; otherwise EXMEM_MemWriteData is used.
REQ-016 Address decode SHALL be:
- 0x0000_0000–0x0000_03FF: 256x32 RAM, index addr[9:2].
- 0x4000_0000: TH.
- 0x4000_0004: TL.
- 0x4000_0008: TCON[2:0].
- 0x4000_000C: leds.
- 0x4000_0010: digits.
- 0x4000_0014: systick (read-only).
REQ-017 Address bits [1:0] SHALL be ignored.
REQ-018 Reads from unmapped addresses SHALL return 0; writes to unmapped addresses SHALL be discarded.
REQ-019 Reads SHALL be combinational from current state; read data is captured into MEM/WB at the next edge (one-cycle stage latency).
REQ-020 Writes (RAM or peripheral) SHALL occur on the rising edge only when EXMEM_MemWrite=1 and MEMWBop=0.
REQ-021 Unused upper bits of narrow registers SHALL read as 0.
REQ-022 MEMWBop=0: MEMWB_RegWrite←EXMEM_RegWrite; MEMWB_WriteRegAddr←EXMEM_WriteRegAddr; MEMWB_RegWriteData←(EXMEM_MemtoReg ? read data : EXMEM_ALUout).
REQ-023 MEMWBop=1: all MEM/WB outputs←0.
REQ-024 MEMWBop=2 or 3: all MEM/WB outputs hold their values.
REQ-025 Timer: while TCON[0]=1, each cycle TL←TL+1.
REQ-026 Timer overflow: when TL=0xFFFF_FFFF, TL←TH instead of incrementing, and TCON[2]←1 if TCON[1]=1.
REQ-027 A software write to TL or TCON in the same cycle as timer activity SHALL win over the count or overflow update.
REQ-028 TCON[2] SHALL be cleared only by software writing 0 to TCON bit 2.
REQ-029 systick SHALL increment every cycle regardless of MEMWBop and wrap from 0xFFFF_FFFF to 0.
REQ-030 Timer and systick SHALL keep counting during stall and flush.

Reset
REQ-031 On reset, the following SHALL all be cleared to 0: MEM/WB outputs, TH, TL, TCON, leds, digits, systick, irq.
REQ-032 RAM contents are not reset.
REQ-033 Reset mid-stall SHALL discard the held MEM/WB values and any pending write.

Verification
REQ-034 sw 0x12345678 to 0x10, then lw 0x10 with MemtoReg=1 → MEMWB_RegWriteData=0x12345678 one edge after the load is presented.
REQ-035 MEMWB holds RegWrite=1, addr=5, data=0xAA; sw with EXMEM_rt=5, MemWriteData=0x11 → RAM stores 0xAA; repeat with rt=0 and MEMWB addr=0 → RAM stores 0x11.
REQ-036 TH=0xFFFF_FFFE, TL=0xFFFF_FFFE, TCON=3 → TL reads 0xFFFF_FFFF, then 0xFFFF_FFFE after reload; irq=1 from the overflow edge; writing TCON=3 clears irq.
REQ-037 MEMWBop=2 with MemWrite=1 to leds=0x5A → leds unchanged and MEM/WB held; then MEMWBop=1 → MEM/WB all 0; then MEMWBop=0 → leds=0x5A.
REQ-038 Assert reset asynchronously between edges with leds=0xFF and TCON=7 → leds=0, irq=0, MEMWB outputs 0 immediately, without waiting for clk.
